// File: rtl/led_command_driver_if.sv
// Command bus between the processor's LED register region and the LED driver.
// The master owns the command vector and strobe; the slave answers with an apply acknowledge.
interface led_command_driver_if #(
  parameter int NUM_LEDS = 9,
  parameter int CMD_W    = 16
);
  logic [NUM_LEDS*CMD_W-1:0] led_commands;
  logic                      cmd_valid;
  logic                      cmd_ack;

  modport master (output led_commands, output cmd_valid, input cmd_ack);
  modport slave  (input led_commands, input cmd_valid, output cmd_ack);
endinterface

// File: rtl/led_command_driver.sv
// PWM/blink driver for the red/green LED pairs. Commands are staged in a shadow
// register and promoted to the active set only at a frame boundary, so pins never glitch mid-frame.
module led_command_driver #(
  parameter int NUM_LEDS = 9,
  parameter int CMD_W    = 16,
  parameter int PRESCALE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  led_command_driver_if.slave   cmd_if,
  output logic [2*NUM_LEDS-1:0] led_pins,
  output logic                  frame_start
);

  localparam int VEC_W = NUM_LEDS * CMD_W;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Field offsets inside one LED command.
  localparam int MODE_LSB  = 14;
  localparam int RATE_LSB  = 12;
  localparam int RED_LSB   = 4;
  localparam int GREEN_LSB = 0;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  logic [PS_W-1:0]       prescale_cnt_q, prescale_cnt_d;
  logic [3:0]            pwm_cnt_q, pwm_cnt_d;
  logic [6:0]            frame_cnt_q, frame_cnt_d;
  logic [VEC_W-1:0]      shadow_q, shadow_d;
  logic [VEC_W-1:0]      active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  cmd_ack_q, cmd_ack_d;
  logic [2*NUM_LEDS-1:0] led_pins_q, led_pins_d;
  logic                  frame_start_q, frame_start_d;

  logic tick;
  logic boundary;

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    tick           = (prescale_cnt_q == PS_LAST);
    boundary       = tick && (pwm_cnt_q == 4'hF);
    prescale_cnt_d = tick ? '0 : prescale_cnt_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
    frame_cnt_d    = boundary ? frame_cnt_q + 7'd1 : frame_cnt_q;
    frame_start_d  = boundary;
  end

  // A strobe landing on the boundary goes straight to the active set and supersedes any pending shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    cmd_ack_d = 1'b0;
    if (boundary) begin
      if (cmd_if.cmd_valid) begin
        active_d  = cmd_if.led_commands;
        pending_d = 1'b0;
        cmd_ack_d = 1'b1;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
        cmd_ack_d = 1'b1;
      end
    end else if (cmd_if.cmd_valid) begin
      shadow_d  = cmd_if.led_commands;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    logic [1:0] rate;
    logic       on;
    led_pins_d = '0;
    rate       = '0;
    on         = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      rate = active_q[i*CMD_W + RATE_LSB +: 2];
      unique case (mode_e'(active_q[i*CMD_W + MODE_LSB +: 2]))
        MODE_SOLID: on = 1'b1;
        MODE_BLINK: on = frame_cnt_q[3'(rate) + 3'd3];
        default:    on = 1'b0;
      endcase
      led_pins_d[2*i]   = on && (pwm_cnt_q < active_q[i*CMD_W + RED_LSB   +: 4]);
      led_pins_d[2*i+1] = on && (pwm_cnt_q < active_q[i*CMD_W + GREEN_LSB +: 4]);
    end
  end

  // NOTE: shadow and active are ordinary registers, not a memory array, so they are cleared on reset like the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      cmd_ack_q      <= 1'b0;
      led_pins_q     <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      cmd_ack_q      <= cmd_ack_d;
      led_pins_q     <= led_pins_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign cmd_if.cmd_ack = cmd_ack_q;
  assign led_pins       = led_pins_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_led_command_driver.sv
// Scoreboarded bench for led_command_driver: per-frame high-time of every pin is
// predicted from the written commands and compared when the frame has been observed.
module tb_led_command_driver;

  localparam int NUM_LEDS = 9;
  localparam int CMD_W    = 16;
  localparam int PRESCALE = 4;
  localparam int VEC_W    = NUM_LEDS * CMD_W;
  localparam int NPIN     = 2 * NUM_LEDS;
  localparam int FRAME    = 16 * PRESCALE;

  typedef struct {
    int frame;
    int cnt[NPIN];
  } frame_exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NPIN-1:0] led_pins;
  logic            frame_start;

  led_command_driver_if #(.NUM_LEDS(NUM_LEDS), .CMD_W(CMD_W)) cmd_if ();

  led_command_driver #(.NUM_LEDS(NUM_LEDS), .CMD_W(CMD_W), .PRESCALE(PRESCALE)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_if      (cmd_if),
    .led_pins    (led_pins),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  frame_exp_t       exp_q[$];
  int               errors    = 0;
  int               checks    = 0;
  int               ack_count = 0;
  int               frame_num = 0;
  logic [VEC_W-1:0] model_vec = '0;

  // Expected high clocks per pin for one frame, from the command format and blink half-period.
  function automatic frame_exp_t expect_frame(input logic [VEC_W-1:0] v, input int frame);
    frame_exp_t e;
    e.frame = frame;
    for (int i = 0; i < NUM_LEDS; i++) begin
      logic [15:0] c;
      int          half;
      bit          on;
      c    = v[i*16 +: 16];
      half = 8 << c[13:12];
      case (c[15:14])
        2'b01:   on = 1'b1;
        2'b10:   on = (((frame % 128) / half) % 2) == 1;
        default: on = 1'b0;
      endcase
      e.cnt[2*i]   = on ? PRESCALE * int'(c[7:4]) : 0;
      e.cnt[2*i+1] = on ? PRESCALE * int'(c[3:0]) : 0;
    end
    return e;
  endfunction

  function automatic logic [VEC_W-1:0] set_led(input logic [VEC_W-1:0] v, input int idx,
                                               input logic [15:0] cmd);
    logic [VEC_W-1:0] r;
    r = v;
    r[idx*16 +: 16] = cmd;
    return r;
  endfunction

  task automatic step();
    @(negedge clock);
    if (cmd_if.cmd_ack) ack_count++;
    if (frame_start)    frame_num++;
  endtask

  // Starts on the frame_start cycle, observes one frame (optionally writing at cycles at0/at1),
  // and ends on the next frame_start cycle.
  task automatic measure_frame(input string tag, input int n_wr,
                               input int at0, input logic [VEC_W-1:0] v0,
                               input int at1, input logic [VEC_W-1:0] v1);
    frame_exp_t e;
    int got[NPIN];
    int acks0;
    int early_fs;
    int exp_ack;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, required one entry", tag);
      return;
    end
    e        = exp_q.pop_front();
    acks0    = ack_count;
    early_fs = 0;
    for (int p = 0; p < NPIN; p++) got[p] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (n_wr > 0 && i == at0) begin
        cmd_if.led_commands = v0;
        cmd_if.cmd_valid    = 1'b1;
      end else if (n_wr > 1 && i == at1) begin
        cmd_if.led_commands = v1;
        cmd_if.cmd_valid    = 1'b1;
      end else begin
        cmd_if.cmd_valid = 1'b0;
      end
      step();
      for (int p = 0; p < NPIN; p++) got[p] += int'(led_pins[p]);
      if (frame_start && i != FRAME - 1) early_fs++;
    end
    cmd_if.cmd_valid = 1'b0;
    for (int p = 0; p < NPIN; p++) begin
      checks++;
      if (got[p] !== e.cnt[p]) begin
        errors++;
        $display("FAIL %s pin%0d (frame %0d): high %0d clocks, required %0d", tag, p, e.frame, got[p], e.cnt[p]);
      end
    end
    checks++;
    if (frame_start !== 1'b1 || early_fs != 0) begin
      errors++;
      $display("FAIL %s frame_period: frame_start=%b early_pulses=%0d, required 1 and 0", tag, frame_start, early_fs);
    end
    exp_ack = (n_wr > 0) ? 1 : 0;
    checks++;
    if ((ack_count - acks0) !== exp_ack || cmd_if.cmd_ack !== exp_ack[0]) begin
      errors++;
      $display("FAIL %s cmd_ack: pulses=%0d ack_at_frame_start=%b, required %0d", tag, ack_count - acks0, cmd_if.cmd_ack, exp_ack);
    end
    if (n_wr > 0) model_vec = (n_wr > 1) ? v1 : v0;
    exp_q.push_back(expect_frame(model_vec, frame_num));
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.led_commands = '0;
    for (int i = 0; i < 5; i++) begin
      cmd_if.cmd_valid    = ~cmd_if.cmd_valid;
      cmd_if.led_commands = {NUM_LEDS{16'h40FF}};
      step();
      checks++;
      if ({led_pins, cmd_if.cmd_ack, frame_start} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: pins=%h ack=%b fs=%b, required all 0", led_pins, cmd_if.cmd_ack, frame_start);
      end
    end
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.led_commands = '0;
    reset     = 1'b1;
    frame_num = 0;
    ack_count = 0;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 4 * FRAME);
    checks++;
    if (n != FRAME || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_frame: first frame_start after %0d clocks, required %0d", n, FRAME);
    end
    checks++;
    if (ack_count != 0) begin
      errors++;
      $display("FAIL reset_no_ack: %0d acks, required 0", ack_count);
    end
    exp_q.push_back(expect_frame(model_vec, frame_num));
  endtask

  task automatic test_solid();
    logic [VEC_W-1:0] v;
    v = set_led('0, 0, 16'h40F8);
    measure_frame("solid_write", 1, 10, v, 0, '0);
    measure_frame("solid_pwm_a", 0, 0, '0, 0, '0);
    measure_frame("solid_pwm_b", 0, 0, '0, 0, '0);
  endtask

  task automatic test_glitch_free();
    logic [VEC_W-1:0] v1, v2;
    v1 = set_led(model_vec, 3, 16'h4044);
    v2 = set_led(model_vec, 3, 16'h40CC);
    measure_frame("glitch_write", 2, 20, v1, 40, v2);
    measure_frame("glitch_new", 0, 0, '0, 0, '0);
  endtask

  task automatic test_simultaneous();
    logic [VEC_W-1:0] va, vb;
    va = set_led(model_vec, 8, 16'h4011);
    vb = set_led(model_vec, 8, 16'h40F0);
    measure_frame("simul_write", 2, 30, va, FRAME - 1, vb);
    measure_frame("simul_new", 0, 0, '0, 0, '0);
  endtask

  task automatic test_off_reserved();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_LEDS; i++) v = set_led(v, i, (i % 2) ? 16'hC0FF : 16'h00FF);
    measure_frame("off_write", 1, 5, v, 0, '0);
    measure_frame("off_frame", 0, 0, '0, 0, '0);
  endtask

  task automatic test_blink();
    logic [VEC_W-1:0] v;
    v = set_led('0, 2, 16'h80F0);
    measure_frame("blink0_write", 1, 12, v, 0, '0);
    for (int f = 0; f < 32; f++) measure_frame("blink_rate0", 0, 0, '0, 0, '0);
    v = set_led('0, 2, 16'h90F0);
    measure_frame("blink1_write", 1, 12, v, 0, '0);
    for (int f = 0; f < 40; f++) measure_frame("blink_rate1", 0, 0, '0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_solid();
    test_glitch_free();
    test_simultaneous();
    test_off_reserved();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_command_driver.md
Name: led_command_driver

Overview:
Consumes the 144-bit LED command vector written by the processor (9 LEDs × 16-bit command) and drives the 18 physical LED pins (red/green per mole) with PWM brightness and optional blinking. Commands are captured into a shadow register on a write strobe and applied to the active set only at PWM frame boundaries, so pins never glitch mid-frame. The block sits between the processor's memory-mapped LED region and the top-level led_pins output.

Parameters:
NUM_LEDS, 9, number of LEDs (moles); led_pins width is 2*NUM_LEDS
CMD_W, 16, bits per LED command
PRESCALE, 4, clock cycles per PWM tick (≥1)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
led_commands  input  NUM_LEDS*CMD_W  command vector; LED i occupies bits [16i+15:16i]
cmd_valid  input  1  one-cycle strobe: led_commands holds a new command set
cmd_ack  output  1  one-cycle pulse when a captured command set becomes active
led_pins  output  2*NUM_LEDS  led_pins[2i] = red of LED i, led_pins[2i+1] = green of LED i
frame_start  output  1  one-cycle pulse on the first clock of each PWM frame

Behaviour:
- Command format per LED: [15:14] mode (00 off, 01 solid, 10 blink, 11 treated as off); [13:12] blink rate; [11:8] ignored; [7:4] red duty; [3:0] green duty.
- Reset (reset=0, async): prescale_cnt, pwm_cnt (4b), frame_cnt (7b), shadow, active, pending = 0; led_pins, cmd_ack, frame_start = 0. Behaviour resumes on the first clock edge after reset=1. Reset mid-frame discards shadow/pending; no ack is issued.
- Tick: prescale_cnt counts 0..PRESCALE-1, wraps; pwm_cnt increments when prescale_cnt = PRESCALE-1, wraps 15→0. Frame = 16*PRESCALE clocks (64 by default).
- Boundary cycle B: prescale_cnt = PRESCALE-1 and pwm_cnt = 15. At B, frame_cnt increments (wraps 127→0).
- Capture: cmd_valid=1 in a non-B cycle → shadow <= led_commands, pending <= 1. A second cmd_valid before B overwrites shadow (last wins); only one ack.
- Apply: at B with pending=1 → active <= shadow, pending <= 0, cmd_ack = 1 in the following cycle.
- Simultaneous: cmd_valid=1 at B → active <= led_commands directly (bypasses shadow), pending <= 0, cmd_ack pulses next cycle, regardless of the prior pending state.
- cmd_valid with no pending at B and no strobe → active unchanged, no ack.
- frame_start = 1 in the cycle after B (first clock of the new frame); the first pulse comes 16*PRESCALE clocks after reset release.
- Pin function (combinational f, then registered, 1-clock latency): on = (mode=01) or (mode=10 and frame_cnt[3+rate]=1); red = on and (pwm_cnt < red_duty); green = on and (pwm_cnt < green_duty). Duty 0 → always low; duty 15 → high 15 of 16 ticks.
- Blink half-period = 2^(3+rate) frames: rate 0 → 8 frames, rate 3 → 64 frames.
- New active values affect led_pins starting from the first clock of the new frame (the cycle frame_start is high computes with the new active; pins reflect it one clock later).

Test Plan:
- Reset: hold reset=0 for 5 clocks with cmd_valid toggling → led_pins=0, cmd_ack=0, frame_start=0; after release, first frame_start exactly 64 clocks later.
- Solid PWM: LED0 = 0x40F8 (solid, red 15, green 8), cmd_valid at clock 10 → cmd_ack at the next frame start; thereafter per 64-clock frame led_pins[0] is high 60 clocks and led_pins[1] high 32 clocks; all other pins 0.
- Glitch-free update: mid-frame, write LED3 = 0x4044 (solid, 4/4) and then 0x40CC before B → no change until B; single cmd_ack; the next frame shows duty 12 (48 of 64 clocks) on pins 6 and 7.
- Simultaneous strobe: cmd_valid asserted exactly at B with LED8 = 0x40F0 while an older shadow is pending → active takes the new value, one ack; pin 16 high 60 clocks per frame, pin 17 low.
- Blink: LED2 = 0x80F0 (blink, rate 0, red 15) → pin 4 PWMs for 8 frames, is low for 8 frames, repeating; rate 1 (0x90F0) → 16-frame halves.
- Off/reserved: mode 00 or 11 with duty 0xFF → pins stay 0 for the whole frame; cmd_ack still pulses once.
